// File: rtl/prpg_sig_analyzer.sv
// prpg_sig_analyzer: MISR compactor for the LFSR pattern stream with
// Hamming-distance statistics and a golden-signature pass/fail check.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   cfg_tap, num_pats,   run config, latched on start
//   golden, start
//   pat_valid, pat_data  pattern input, accepted while pat_ready
//   pat_ready            high exactly in RUN
//   busy, done, pass     run status; pass valid while done
//   signature, pat_cnt   current MISR value and accepted-pattern count
//   hd_last, hd_sum,     Hamming-distance stats between consecutive
//   hd_max               accepted patterns
module prpg_sig_analyzer #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-2:0]     cfg_tap,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pats,
    input  logic [0:W-1]     golden,
    input  logic             pat_valid,
    input  logic [0:W-1]     pat_data,
    output logic             pat_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [0:W-1]     signature,
    output logic [CNT_W-1:0] pat_cnt,
    output logic [3:0]       hd_last,
    output logic [11:0]      hd_sum,
    output logic [3:0]       hd_max
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-2:0]     tap_q;
    logic [CNT_W-1:0] num_q;
    logic [0:W-1]     gold_q;
    logic [0:W-1]     prev_q;
    logic [0:W-1]     sig_nxt;
    logic [0:W-1]     diff;
    logic [3:0]       h;
    logic             accept;
    logic             take_start;
    logic             last;

    assign accept     = (state == RUN) && pat_valid;
    assign take_start = (state != RUN) && start;
    assign last       = accept && ((pat_cnt + CNT_W'(1)) == num_q);

    assign pat_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_comb begin
        sig_nxt    = '0;
        sig_nxt[0] = signature[W-1] ^ pat_data[0];
        for (int i = 1; i < W; i++) begin
            sig_nxt[i] = (tap_q[W-1-i] ? (signature[W-1] ^ signature[i-1])
                                       : signature[i-1]) ^ pat_data[i];
        end
    end

    always_comb begin
        diff = pat_data ^ prev_q;
        h    = '0;
        for (int i = 0; i < W; i++) begin
            h = h + {3'b000, diff[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_pats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q     <= '0;
            num_q     <= '0;
            gold_q    <= '0;
            prev_q    <= '0;
            signature <= '0;
            pat_cnt   <= '0;
            hd_last   <= '0;
            hd_sum    <= '0;
            hd_max    <= '0;
            pass      <= 1'b0;
        end else if (take_start) begin
            tap_q     <= cfg_tap;
            num_q     <= num_pats;
            gold_q    <= golden;
            prev_q    <= '0;
            signature <= '0;
            pat_cnt   <= '0;
            hd_last   <= '0;
            hd_sum    <= '0;
            hd_max    <= '0;
            // An empty run compares the cleared signature immediately.
            pass      <= (num_pats == '0) && (golden == '0);
        end else if (accept) begin
            signature <= sig_nxt;
            pat_cnt   <= pat_cnt + CNT_W'(1);
            hd_last   <= h;
            hd_sum    <= hd_sum + {8'b0, h};
            if (h > hd_max) begin
                hd_max <= h;
            end
            prev_q    <= pat_data;
            if (last) begin
                pass <= (sig_nxt == gold_q);
            end
        end
    end

endmodule

// File: tb/tb_prpg_sig_analyzer.sv
// tb_prpg_sig_analyzer: scoreboard bench for prpg_sig_analyzer.
// Stimulus pushes expected per-pattern results; a monitor pops and compares.
module tb_prpg_sig_analyzer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  cfg_tap;
    logic        start;
    logic [7:0]  num_pats;
    logic [7:0]  golden;
    logic        pat_valid;
    logic [7:0]  pat_data;
    logic        pat_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  signature;
    logic [7:0]  pat_cnt;
    logic [3:0]  hd_last;
    logic [11:0] hd_sum;
    logic [3:0]  hd_max;

    prpg_sig_analyzer #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_tap(cfg_tap), .start(start),
        .num_pats(num_pats), .golden(golden), .pat_valid(pat_valid),
        .pat_data(pat_data), .pat_ready(pat_ready), .busy(busy),
        .done(done), .pass(pass), .signature(signature),
        .pat_cnt(pat_cnt), .hd_last(hd_last), .hd_sum(hd_sum),
        .hd_max(hd_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sig;
        logic [7:0]  cnt;
        logic [3:0]  hl;
        logic [11:0] hs;
        logic [3:0]  hm;
        bit          last;
        bit          pass;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   pend = 0;

    logic [6:0]  m_tap;
    logic [7:0]  m_sig, m_prev, m_num, m_gold, m_cnt;
    logic [11:0] m_hs;
    logic [3:0]  m_hm;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Galois view of the register: shift toward index W-1, fold the
    // outgoing bit back through {1,tap}, then xor the pattern in.
    function automatic logic [7:0] misr(logic [7:0] v, logic [7:0] d,
                                        logic [6:0] tap);
        return (v >> 1) ^ (v[0] ? {1'b1, tap} : 8'h00) ^ d;
    endfunction

    task automatic model_start(logic [6:0] tap, logic [7:0] n, logic [7:0] g);
        m_tap = tap; m_num = n; m_gold = g;
        m_sig = 0; m_prev = 0; m_cnt = 0; m_hs = 0; m_hm = 0;
    endtask

    task automatic model_accept(logic [7:0] d);
        exp_t e;
        int   hd;
        hd     = $countones(d ^ m_prev);
        m_sig  = misr(m_sig, d, m_tap);
        m_prev = d;
        m_cnt  = m_cnt + 1;
        m_hs   = m_hs + 12'(hd);
        if (hd > int'(m_hm)) m_hm = 4'(hd);
        e.sig = m_sig; e.cnt = m_cnt; e.hl = 4'(hd);
        e.hs = m_hs; e.hm = m_hm;
        e.last = (m_cnt == m_num);
        e.pass = (m_sig == m_gold);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ready"}, pat_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_sig"}, signature, 0);
        chk({tag, "_cnt"}, pat_cnt, 0);
        chk({tag, "_hd"}, {hd_last, hd_sum, hd_max}, 0);
    endtask

    task automatic do_start(logic [6:0] tap, logic [7:0] n, logic [7:0] g,
                            bit with_valid);
        cfg_tap = tap; num_pats = n; golden = g; start = 1;
        pat_valid = with_valid; pat_data = 8'($urandom);
        model_start(tap, n, g);
        tick();
        start = 0; pat_valid = 0;
        cfg_tap = 7'($urandom); num_pats = 8'($urandom); golden = 8'($urandom);
        if (n == 0) begin
            chk("empty_done", done, 1);
            chk("empty_busy", busy, 0);
            chk("empty_ready", pat_ready, 0);
            chk("empty_pass", pass, (g == 0));
        end else begin
            chk("start_busy", busy, 1);
            chk("start_ready", pat_ready, 1);
            chk("start_done", done, 0);
            chk("start_clear", {signature, pat_cnt, hd_last, hd_sum, hd_max}, 0);
        end
    endtask

    task automatic send(logic [7:0] d, int gap);
        int t = 0;
        while (!pat_ready && t < 50) begin
            tick();
            t++;
        end
        if (!pat_ready) begin
            chk("ready_timeout", pat_ready, 1);
            return;
        end
        pat_valid = 1; pat_data = d;
        model_accept(d);
        tick();
        pat_valid = 0;
        for (int k = 0; k < gap; k++) begin
            pat_data = 8'($urandom);
            if (m_cnt != m_num) start = 1'($urandom);
            num_pats = 8'($urandom_range(0, 3));
            tick();
        end
        start = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || pend) && t < 20) begin
            tick();
            t++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (q.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sig", signature, e.sig);
                    chk("pat_cnt", pat_cnt, e.cnt);
                    chk("hd_last", hd_last, e.hl);
                    chk("hd_sum", hd_sum, e.hs);
                    chk("hd_max", hd_max, e.hm);
                    chk("done", done, e.last);
                    chk("busy", busy, !e.last);
                    chk("ready", pat_ready, !e.last);
                    if (e.last) chk("pass", pass, e.pass);
                end
            end
            pend = pat_valid && pat_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] g;
        logic [6:0] tp;
        int         n;
        rst_n = 0; start = 0; pat_valid = 0; pat_data = 0;
        cfg_tap = 0; num_pats = 0; golden = 0;
        tick(); tick();
        check_zero("reset");
        rst_n = 1;
        tick();

        do_start(7'($urandom), 10, 8'($urandom), 0);
        for (int i = 0; i < 3; i++) send(8'($urandom), 0);
        drain();
        rst_n = 0;
        #1;
        check_zero("midrst");
        q.delete();
        tick();
        rst_n = 1;
        tick();
        do_start(7'($urandom), 1, 8'h5A, 1);
        send(8'h5A, 0);
        drain();
        chk("t1_pass", pass, 1);

        do_start(7'b0100101, 2, 8'b10100101, 1);
        send(8'b00000001, 0);
        send(8'b00000000, 0);
        drain();
        chk("t2_sig", signature, 8'b10100101);
        chk("t2_pass", pass, 1);

        do_start(7'b0100101, 2, 8'hA4, 0);
        send(8'b00000001, 0);
        send(8'b00000000, 0);
        drain();
        chk("t3_pass", pass, 0);
        chk("t3_done", done, 1);

        do_start(7'($urandom), 3, 8'($urandom), 0);
        send(8'($urandom), 2);
        send(8'($urandom), 1);
        send(8'($urandom), 0);
        drain();
        tick(); tick();
        chk("t4_ready_after", pat_ready, 0);
        chk("t4_cnt", pat_cnt, 3);

        do_start(7'($urandom), 0, 8'h00, 1);
        do_start(7'($urandom), 0, 8'h01, 0);

        do_start(7'($urandom), 3, 8'($urandom), 0);
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'hFF, 0);
        drain();
        chk("t6_max", hd_max, 8);
        chk("t6_sum", hd_sum, 8);
        do_start(7'($urandom), 4, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 0);
        drain();

        for (int r = 0; r < 12; r++) begin
            n  = $urandom_range(1, 20);
            tp = 7'($urandom);
            d.delete();
            g  = 0;
            for (int i = 0; i < n; i++) begin
                d.push_back(8'($urandom));
                g = misr(g, d[i], tp);
            end
            if ($urandom_range(0, 1) == 0) g = g ^ (8'h01 << $urandom_range(0, 7));
            do_start(tp, 8'(n), g, 1'($urandom));
            for (int i = 0; i < n; i++) send(d[i], $urandom_range(0, 2));
            drain();
        end

        do_start(7'($urandom), 255, 8'($urandom), 0);
        for (int i = 0; i < 255; i++) send(8'($urandom), 0);
        drain();
        chk("max_cnt", pat_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
